// File: rtl/mod_pkg.sv
// mod_pkg: shared types and constants for the digital modulator
package mod_pkg;
    typedef enum logic [1:0] {
        MOD_ASK  = 2'd0,
        MOD_BPSK = 2'd1,
        MOD_FSK  = 2'd2,
        MOD_CW   = 2'd3
    } mod_t;
    localparam int SAMPLE_W = 12;
    localparam int MIDSCALE = 2048;
    localparam logic [14:0] PRBS_TAPS = 15'h6000;
endpackage

// File: rtl/digital_modulator_prbs15.sv
// prbs15: x^15+x^14+1 Fibonacci LFSR; bit_out is the bit the next advance will produce
module prbs15 (
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    input  logic [14:0] seed,
    output logic        bit_out
);
    import mod_pkg::*;
    logic [14:0] lfsr;
    logic [14:0] lfsr_next;
    // shift in the tap parity, or recover from the all-zero lock-up state by reloading the seed
    always_comb lfsr_next = (lfsr == '0) ? seed : {lfsr[13:0], ^(lfsr & PRBS_TAPS)};
    assign bit_out = lfsr_next[0];
    // one step per advance request
    always_ff @(posedge clk or posedge reset)
        if (reset)
            lfsr <= seed;
        else if (adv)
            lfsr <= lfsr_next;
endmodule

// File: rtl/digital_modulator.sv
// digital_modulator: PRBS-driven ASK/BPSK/FSK/CW modulator around an external carrier generator
module digital_modulator #(
    parameter int          SAMPLE_W  = 12,
    parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mod_sel,
    input  logic [31:0]         baud_div,
    input  logic [31:0]         base_phase_inc,
    input  logic [31:0]         fsk_phase_inc,
    input  logic [SAMPLE_W-1:0] sin_in,
    output logic [31:0]         phase_inc_out,
    output logic [SAMPLE_W-1:0] mod_out,
    output logic                data_bit,
    output logic                bit_strobe
);
    import mod_pkg::*;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    logic [31:0] cnt;
    logic        boundary;
    logic        strobe_r;
    logic        prbs_bit;
    mod_t        mode;
    // a symbol ends on the last count of baud_div; 0 and 1 both mean every enabled cycle
    always_comb boundary = en && (baud_div <= 32'd1 || cnt >= baud_div - 32'd1);
    prbs15 u_prbs (
        .clk     (clk),
        .reset   (reset),
        .adv     (boundary),
        .seed    (PRBS_SEED),
        .bit_out (prbs_bit)
    );
    // symbol timing, current data bit and the mode latched for the symbol in progress
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt      <= '0;
            strobe_r <= 1'b0;
            data_bit <= 1'b0;
            mode     <= MOD_CW;
        end else begin
            strobe_r <= boundary;
            if (en)
                cnt <= boundary ? '0 : cnt + 32'd1;
            if (boundary) begin
                data_bit <= prbs_bit;
                mode     <= mod_t'(mod_sel);
            end
        end
    // the strobe is masked so a freshly disabled block never shows a stale pulse
    assign bit_strobe = strobe_r & en;
    // modulated sample and carrier tuning word for the symbol in progress
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mod_out       <= MID;
            phase_inc_out <= '0;
        end else if (en) begin
            mod_out       <= (mode == MOD_ASK && !data_bit) ? MID :
                             (mode == MOD_BPSK && !data_bit) ? ~sin_in : sin_in;
            phase_inc_out <= (mode == MOD_FSK && data_bit) ? fsk_phase_inc : base_phase_inc;
        end
endmodule

// File: tb/tb_digital_modulator.sv
// tb_digital_modulator: scoreboard bench with a symbol-level reference model of the modulator
module tb_digital_modulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mod_sel = 2'd0;
    logic [31:0] baud_div = 32'd10;
    logic [31:0] base_phase_inc = '0;
    logic [31:0] fsk_phase_inc = '0;
    logic [11:0] sin_in = '0;
    logic [31:0] phase_inc_out;
    logic [11:0] mod_out;
    logic        data_bit;
    logic        bit_strobe;
    int n_checks = 0;
    int n_fail = 0;
    typedef struct {
        logic [11:0] mo;
        logic [31:0] pi;
        logic        db;
        logic        bs;
    } exp_t;
    exp_t sb[$];

    digital_modulator dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .mod_sel        (mod_sel),
        .baud_div       (baud_div),
        .base_phase_inc (base_phase_inc),
        .fsk_phase_inc  (fsk_phase_inc),
        .sin_in         (sin_in),
        .phase_inc_out  (phase_inc_out),
        .mod_out        (mod_out),
        .data_bit       (data_bit),
        .bit_strobe     (bit_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] prbs_step(input logic [14:0] s);
        int v;
        v = int'(s);
        if (v == 0)
            return 15'h7FFF;
        v = ((v << 1) | (((v >> 14) ^ (v >> 13)) & 1)) & 32'h7FFF;
        return v[14:0];
    endfunction

    longint      m_cnt = 0;
    logic [14:0] m_lfsr = 15'h7FFF;
    logic        m_bit = 1'b0;
    int          m_mode = 3;
    exp_t        m_e = '{12'd2048, 32'd0, 1'b0, 1'b0};

    always @(posedge clk) begin
        longint bd;
        if (reset) begin
            m_cnt = 0;
            m_lfsr = 15'h7FFF;
            m_bit = 1'b0;
            m_mode = 3;
            m_e.mo = 12'd2048;
            m_e.pi = 32'd0;
            m_e.bs = 1'b0;
        end else if (en) begin
            bd = (baud_div == 0) ? 64'd1 : longint'(baud_div);
            case (m_mode)
                0: m_e.mo = m_bit ? sin_in : 12'd2048;
                1: m_e.mo = m_bit ? sin_in : 12'(4095 - int'(sin_in));
                default: m_e.mo = sin_in;
            endcase
            m_e.pi = (m_mode == 2 && m_bit) ? fsk_phase_inc : base_phase_inc;
            m_cnt++;
            m_e.bs = (m_cnt >= bd);
            if (m_e.bs) begin
                m_cnt = 0;
                m_lfsr = prbs_step(m_lfsr);
                m_bit = m_lfsr[0];
                m_mode = int'(mod_sel);
            end
        end else begin
            m_e.bs = 1'b0;
        end
        m_e.db = m_bit;
        sb.push_back(m_e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("mod_out", 32'(mod_out), 32'(e.mo));
            chk("phase_inc_out", phase_inc_out, e.pi);
            chk("data_bit", 32'(data_bit), 32'(e.db));
            chk("bit_strobe", 32'(bit_strobe), 32'(e.bs));
        end
    end

    task automatic wait_strobe(input int lim, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bit_strobe && n < lim);
        if (!bit_strobe) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got none within %0d cycles at %0t", lim, $time);
        end
    endtask

    initial begin
        int n;
        logic [14:0] r;
        bit saw1, saw0, sawb, sawf;
        saw1 = 0; saw0 = 0; sawb = 0; sawf = 0;
        reset = 1'b1;
        en = 1'b1;
        baud_div = 32'd10;
        base_phase_inc = 32'd42950;
        fsk_phase_inc = 32'd85900;
        sin_in = 12'd3000;
        mod_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_mod_out", 32'(mod_out), 32'd2048);
        chk("reset_phase_inc", phase_inc_out, 32'd0);
        chk("reset_strobe", 32'(bit_strobe), 32'd0);
        chk("reset_data_bit", 32'(data_bit), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("release_phase_inc", phase_inc_out, 32'd42950);
        wait_strobe(50, n);
        chk("first_boundary", n + 1, 32'd10);
        r = prbs_step(15'h7FFF);
        chk("prbs_bit", 32'(data_bit), 32'(r[0]));
        for (int i = 1; i < 8; i++) begin
            wait_strobe(50, n);
            chk("strobe_gap", n, 32'd10);
            r = prbs_step(r);
            chk("prbs_bit", 32'(data_bit), 32'(r[0]));
        end
        @(negedge clk);
        mod_sel = 2'd1;
        baud_div = 32'd1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mod_out == 12'd3000) saw1 = 1;
            if (mod_out == 12'd1095) saw0 = 1;
        end
        chk("bpsk_levels", {saw1, saw0}, 32'd3);
        @(negedge clk);
        mod_sel = 2'd2;
        baud_div = 32'd3;
        repeat (90) begin
            @(posedge clk);
            #1;
            if (phase_inc_out == 32'd42950) sawb = 1;
            if (phase_inc_out == 32'd85900) sawf = 1;
        end
        chk("fsk_tones", {sawb, sawf}, 32'd3);
        @(negedge clk);
        mod_sel = 2'd0;
        baud_div = 32'd10;
        wait_strobe(50, n);
        wait_strobe(50, n);
        chk("ask_gap", n, 32'd10);
        repeat (3) @(negedge clk);
        mod_sel = 2'd1;
        wait_strobe(50, n);
        chk("modsel_boundary", n, 32'd8);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            sin_in = 12'($urandom);
            mod_sel = 2'($urandom);
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_mod_out", 32'(mod_out), 32'd2048);
        chk("async_phase_inc", phase_inc_out, 32'd0);
        chk("async_data_bit", 32'(data_bit), 32'd0);
        chk("async_strobe", 32'(bit_strobe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_strobe(50, n);
        chk("post_reset_boundary", n, 32'd10);
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            en = ($urandom % 8) != 0;
            sin_in = 12'($urandom);
            if ($urandom % 16 == 0) mod_sel = 2'($urandom);
            if ($urandom % 64 == 0) baud_div = $urandom % 6;
            if ($urandom % 128 == 0) base_phase_inc = $urandom;
            if ($urandom % 128 == 0) fsk_phase_inc = $urandom;
            reset = ($urandom % 500) == 0;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
